// File: rtl/pc_sequencer.sv
// Program counter owner: sequences fetch addresses around taken branches,
// holds a multi-cycle Flush after each redirect, and halts on a misaligned target.
module pc_sequencer #(
    parameter int unsigned    XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter int unsigned    FLUSH_CYCLES = 2
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            Stall,
    input  logic            IMemReady,
    input  logic            Branch,
    input  logic [XLEN-1:0] Target,
    output logic [XLEN-1:0] PC,
    output logic            PCValid,
    output logic            Flush,
    output logic            Trap,
    output logic [1:0]      State
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [3:0]      FLUSH_INIT = 4'(FLUSH_CYCLES);
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);

    state_t          state_reg, state_next;
    logic [XLEN-1:0] pc_reg, pc_next;
    logic            pcvalid_reg, pcvalid_next;
    logic            flush_reg, flush_next;
    logic            trap_reg, trap_next;
    logic [3:0]      cnt_reg, cnt_next;
    logic            adv;

    assign adv = IMemReady & ~Stall;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_reg   <= BOOT;
            pc_reg      <= RESET_PC;
            pcvalid_reg <= 1'b0;
            flush_reg   <= 1'b0;
            trap_reg    <= 1'b0;
            cnt_reg     <= 4'd0;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            pcvalid_reg <= pcvalid_next;
            flush_reg   <= flush_next;
            trap_reg    <= trap_next;
            cnt_reg     <= cnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        pcvalid_next = pcvalid_reg;
        flush_next   = flush_reg;
        trap_next    = trap_reg;
        cnt_next     = cnt_reg;
        case (state_reg)
            BOOT: begin
                state_next   = RUN;
                pcvalid_next = 1'b1;
            end
            RUN: begin
                // A taken branch outranks Stall and IMemReady; misalignment outranks all.
                if (Branch && (Target[1:0] != 2'b00)) begin
                    state_next   = HALT;
                    trap_next    = 1'b1;
                    pcvalid_next = 1'b0;
                end else if (Branch) begin
                    state_next = FLUSH;
                    pc_next    = Target;
                    flush_next = 1'b1;
                    cnt_next   = FLUSH_INIT;
                end else if (adv) begin
                    pc_next = pc_reg + PC_STEP;
                end
            end
            FLUSH: begin
                pcvalid_next = 1'b1;
                flush_next   = 1'b1;
                if (adv) begin
                    pc_next = pc_reg + PC_STEP;
                end
                // Stalled cycles stretch the flush window rather than consuming it.
                if (!Stall) begin
                    if (cnt_reg <= 4'd1) begin
                        state_next = RUN;
                        flush_next = 1'b0;
                        cnt_next   = 4'd0;
                    end else begin
                        cnt_next = cnt_reg - 4'd1;
                    end
                end
            end
            HALT: begin
                pcvalid_next = 1'b0;
                flush_next   = 1'b0;
                trap_next    = 1'b1;
            end
            default: begin
                state_next = BOOT;
            end
        endcase
    end

    assign PC      = pc_reg;
    assign PCValid = pcvalid_reg;
    assign Flush   = flush_reg;
    assign Trap    = trap_reg;
    assign State   = state_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: boot, sequential fetch, flush windows,
// stall interaction, wrap-around, misaligned-target halt and asynchronous reset.
module tb_pc_sequencer;

    logic        CLK;
    logic        RESET;
    logic        Stall;
    logic        IMemReady;
    logic        Branch;
    logic [31:0] Target;
    logic [31:0] PC;
    logic        PCValid;
    logic        Flush;
    logic        Trap;
    logic [1:0]  State;

    int checks = 0;
    int errors = 0;

    pc_sequencer #(.XLEN(32), .RESET_PC(32'h0), .FLUSH_CYCLES(2)) dut (
        .CLK(CLK), .RESET(RESET), .Stall(Stall), .IMemReady(IMemReady),
        .Branch(Branch), .Target(Target), .PC(PC), .PCValid(PCValid),
        .Flush(Flush), .Trap(Trap), .State(State)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
        $display("t=%0t br=%0d tgt=%h stall=%0d rdy=%0d -> pc=%h valid=%0d flush=%0d trap=%0d state=%0d",
                 $time, Branch, Target, Stall, IMemReady, PC, PCValid, Flush, Trap, State);
    endtask

    task automatic test_reset();
        RESET = 1'b1; Stall = 1'b0; IMemReady = 1'b1; Branch = 1'b0; Target = 32'h0;
        step();
        step();
        checks++; if (PC !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h expected %h", PC, 32'h0); end
        checks++; if (PCValid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", PCValid); end
        checks++; if (Flush !== 1'b0) begin errors++; $display("FAIL rst_flush: got %b expected 0", Flush); end
        checks++; if (Trap !== 1'b0) begin errors++; $display("FAIL rst_trap: got %b expected 0", Trap); end
        checks++; if (State !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d expected 0", State); end
    endtask

    task automatic test_boot_run();
        // Branch during BOOT must be ignored.
        Branch = 1'b1; Target = 32'h300;
        RESET = 1'b0;
        step();
        checks++; if (State !== 2'd1) begin errors++; $display("FAIL boot_state: got %0d expected 1", State); end
        checks++; if (PC !== 32'h0) begin errors++; $display("FAIL boot_pc: got %h expected %h", PC, 32'h0); end
        checks++; if (PCValid !== 1'b1) begin errors++; $display("FAIL boot_valid: got %b expected 1", PCValid); end
        Branch = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            checks++;
            if (PC !== 32'(4 * i)) begin errors++; $display("FAIL run_pc%0d: got %h expected %h", i, PC, 32'(4 * i)); end
        end
        checks++; if (State !== 2'd1) begin errors++; $display("FAIL run_state: got %0d expected 1", State); end
    endtask

    task automatic test_branch();
        Branch = 1'b1; Target = 32'h40;
        step();
        Branch = 1'b0;
        checks++; if (PC !== 32'h40) begin errors++; $display("FAIL br_pc: got %h expected %h", PC, 32'h40); end
        checks++; if (Flush !== 1'b1) begin errors++; $display("FAIL br_flush1: got %b expected 1", Flush); end
        checks++; if (State !== 2'd2) begin errors++; $display("FAIL br_state: got %0d expected 2", State); end
        step();
        checks++; if (PC !== 32'h44) begin errors++; $display("FAIL br_pc2: got %h expected %h", PC, 32'h44); end
        checks++; if (Flush !== 1'b1) begin errors++; $display("FAIL br_flush2: got %b expected 1", Flush); end
        step();
        checks++; if (PC !== 32'h48) begin errors++; $display("FAIL br_pc3: got %h expected %h", PC, 32'h48); end
        checks++; if (Flush !== 1'b0) begin errors++; $display("FAIL br_flush_end: got %b expected 0", Flush); end
        checks++; if (State !== 2'd1) begin errors++; $display("FAIL br_state_end: got %0d expected 1", State); end
    endtask

    task automatic test_branch_stall();
        Branch = 1'b1; Target = 32'h80; Stall = 1'b1;
        step();
        checks++; if (PC !== 32'h80) begin errors++; $display("FAIL bs_pc: got %h expected %h", PC, 32'h80); end
        checks++; if (Flush !== 1'b1) begin errors++; $display("FAIL bs_flush1: got %b expected 1", Flush); end
        // Branch kept high inside FLUSH with a different target: must be ignored.
        Target = 32'h100;
        step();
        checks++; if (PC !== 32'h80) begin errors++; $display("FAIL bs_hold: got %h expected %h", PC, 32'h80); end
        checks++; if (Flush !== 1'b1) begin errors++; $display("FAIL bs_flush2: got %b expected 1", Flush); end
        checks++; if (State !== 2'd2) begin errors++; $display("FAIL bs_state2: got %0d expected 2", State); end
        Stall = 1'b0;
        step();
        checks++; if (PC !== 32'h84) begin errors++; $display("FAIL bs_pc3: got %h expected %h", PC, 32'h84); end
        checks++; if (Flush !== 1'b1) begin errors++; $display("FAIL bs_flush3: got %b expected 1", Flush); end
        Branch = 1'b0;
        step();
        checks++; if (PC !== 32'h88) begin errors++; $display("FAIL bs_pc4: got %h expected %h", PC, 32'h88); end
        checks++; if (Flush !== 1'b0) begin errors++; $display("FAIL bs_flush_end: got %b expected 0", Flush); end
    endtask

    task automatic test_imem_wait();
        IMemReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (PC !== 32'h88) begin errors++; $display("FAIL imem_hold%0d: got %h expected %h", i, PC, 32'h88); end
            checks++; if (PCValid !== 1'b1) begin errors++; $display("FAIL imem_valid%0d: got %b expected 1", i, PCValid); end
        end
        IMemReady = 1'b1;
        step();
        checks++; if (PC !== 32'h8C) begin errors++; $display("FAIL imem_resume: got %h expected %h", PC, 32'h8C); end
    endtask

    task automatic test_wrap();
        Branch = 1'b1; Target = 32'hFFFF_FFF8;
        step();
        Branch = 1'b0;
        step();
        checks++; if (PC !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_top: got %h expected %h", PC, 32'hFFFF_FFFC); end
        step();
        checks++; if (PC !== 32'h0) begin errors++; $display("FAIL wrap_zero: got %h expected %h", PC, 32'h0); end
        checks++; if (Trap !== 1'b0) begin errors++; $display("FAIL wrap_trap: got %b expected 0", Trap); end
        checks++; if (State !== 2'd1) begin errors++; $display("FAIL wrap_state: got %0d expected 1", State); end
    endtask

    task automatic test_reset_mid_flush();
        Branch = 1'b1; Target = 32'h200;
        step();
        Branch = 1'b0;
        checks++; if (Flush !== 1'b1) begin errors++; $display("FAIL mf_flush: got %b expected 1", Flush); end
        RESET = 1'b1;
        #1;
        checks++; if (Flush !== 1'b0) begin errors++; $display("FAIL mf_async_flush: got %b expected 0", Flush); end
        checks++; if (State !== 2'd0) begin errors++; $display("FAIL mf_async_state: got %0d expected 0", State); end
        checks++; if (PC !== 32'h0) begin errors++; $display("FAIL mf_async_pc: got %h expected %h", PC, 32'h0); end
    endtask

    task automatic test_halt();
        step();
        RESET = 1'b0;
        step();
        step();
        checks++; if (PC !== 32'h4) begin errors++; $display("FAIL h_pre_pc: got %h expected %h", PC, 32'h4); end
        Branch = 1'b1; Target = 32'h42;
        step();
        checks++; if (State !== 2'd3) begin errors++; $display("FAIL h_state: got %0d expected 3", State); end
        checks++; if (Trap !== 1'b1) begin errors++; $display("FAIL h_trap: got %b expected 1", Trap); end
        checks++; if (PCValid !== 1'b0) begin errors++; $display("FAIL h_valid: got %b expected 0", PCValid); end
        checks++; if (PC !== 32'h4) begin errors++; $display("FAIL h_pc: got %h expected %h", PC, 32'h4); end
        Target = 32'h100;
        step();
        Branch = 1'b0;
        step();
        checks++; if (PC !== 32'h4) begin errors++; $display("FAIL h_frozen: got %h expected %h", PC, 32'h4); end
        checks++; if (State !== 2'd3) begin errors++; $display("FAIL h_stuck: got %0d expected 3", State); end
        checks++; if (Flush !== 1'b0) begin errors++; $display("FAIL h_flush: got %b expected 0", Flush); end
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        checks++; if (Trap !== 1'b0) begin errors++; $display("FAIL h_rst_trap: got %b expected 0", Trap); end
        checks++; if (PC !== 32'h0) begin errors++; $display("FAIL h_rst_pc: got %h expected %h", PC, 32'h0); end
        step();
        checks++; if (State !== 2'd1) begin errors++; $display("FAIL h_rerun: got %0d expected 1", State); end
    endtask

    initial begin
        test_reset();
        test_boot_run();
        test_branch();
        test_branch_stall();
        test_imem_wait();
        test_wrap();
        test_reset_mid_flush();
        test_halt();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the program counter and sequences instruction fetch around branch resolution.
- Consumes the single-bit Branch decision from the branch unit (BranchEn/IsUncond/funct3/z/lt already reduced upstream) plus the resolved target.
- Produces the fetch PC, a fetch-valid strobe, and a multi-cycle Flush that kills wrong-path instructions in decode/execute.
- Halts on a misaligned branch target.

Parameters:
- XLEN, 32, PC/target width in bits.
- RESET_PC, 0, PC value loaded on reset; must be 4-byte aligned.
- FLUSH_CYCLES, 2, number of non-stalled cycles Flush stays high after a taken branch; legal range 1..15.

Ports:
- CLK  input  1  single system clock; all state updates on rising edge.
- RESET  input  1  asynchronous, active-high reset.
- Stall  input  1  pipeline hold request from hazard logic.
- IMemReady  input  1  instruction memory can accept a fetch this cycle.
- Branch  input  1  taken-branch decision from branch unit, valid in the cycle it is sampled.
- Target  input  XLEN  resolved branch/jump target address.
- PC  output  XLEN  current fetch address, registered.
- PCValid  output  1  PC is a legal fetch request this cycle, registered.
- Flush  output  1  kill decode/execute contents, registered.
- Trap  output  1  sticky misaligned-target error, registered.
- State  output  2  FSM state for debug: BOOT=0, RUN=1, FLUSH=2, HALT=3.

Behaviour:
- Reset (asynchronous, active-high): PC=RESET_PC, PCValid=0, Flush=0, Trap=0, State=BOOT, flush counter=0. Reset asserted mid-operation aborts any flush immediately.
- Define Adv = IMemReady & ~Stall.
- BOOT:
  - Unconditionally moves to RUN next edge, with PCValid=1 and PC held at RESET_PC.
  - Branch is ignored in BOOT.
- RUN, priority order:
  1. Branch=1 and Target[1:0]!=0: go to HALT, Trap=1, PCValid=0, PC unchanged.
  2. Branch=1 with aligned target: PC<=Target, Flush<=1, counter<=FLUSH_CYCLES, go to FLUSH. Branch wins over Stall and IMemReady=0.
  3. Adv=1: PC<=PC+4, modulo 2^XLEN. 0xFFFFFFFC wraps to 0x00000000 with no error.
  4. Otherwise: hold PC.
- FLUSH:
  - Flush=1 and PCValid=1 throughout.
  - PC advances by 4 on Adv, as in RUN.
  - Branch input is ignored, since it comes from an instruction being killed.
  - Counter decrements only on cycles with Stall=0.
  - When the counter is 1 and Stall=0, the next edge moves to RUN and Flush<=0.
  - Total Flush-high cycles = FLUSH_CYCLES + number of stalled cycles inside FLUSH.
- HALT:
  - PCValid=0, Flush=0, Trap=1, PC frozen at the last value.
  - All inputs ignored; only RESET exits.
- Latency: Branch sampled at edge N gives PC=Target and Flush=1 visible after edge N, i.e. one cycle.
- Simultaneous Branch and Stall in RUN: the branch is taken, and the first flush cycle sees Stall per its own value.
- Target bits [1:0] are never silently masked. Misalignment always traps.
- All outputs come directly from flops; no combinational input-to-output paths.

Test Plan:
- Reset release, Stall=0, IMemReady=1, Branch=0 -> BOOT for 1 cycle with PC=0, then PCValid=1, PC=0,4,8,12 on successive cycles, State=1.
- At PC=0x10, Branch=1, Target=0x40 -> next cycle PC=0x40, Flush=1, State=2. Flush high exactly 2 cycles (PC 0x40, 0x44), then Flush=0, PC=0x48, State=1.
- Taken branch to 0x80 with Stall=1 on the first flush cycle -> PC holds 0x80 for that cycle, Flush high 3 cycles total, Branch=1 during FLUSH ignored.
- IMemReady=0 for 3 cycles in RUN at PC=0x20 -> PC stays 0x20, PCValid=1. Then increments to 0x24.
- Branch=1, Target=0x42 -> HALT: Trap=1, PCValid=0, PC frozen. Further Branch/Target changes do nothing until RESET pulse, after which Trap=0 and PC=RESET_PC.
- PC=0xFFFFFFFC with Adv=1 -> PC=0x00000000, Trap=0. RESET asserted mid-FLUSH -> Flush drops asynchronously, State=0.
